// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory, control and decode-side
// signals of the fetch stage.
//
// Handshake (decode side): an entry moves from the fetch stage to decode
// on a rising CLK edge when valid_out and ready_in are both high that
// cycle. valid_out never depends on ready_in. Once raised, valid_out
// holds until the entry is taken, unless a redirect or reset flushes it.
//
// Modports:
//   master - the fetch stage: drives imemREN/imemaddr, valid_out,
//            instr_out, npc_out and count.
//   slave  - the environment: memory, MEM-stage control and decode.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          imemREN;
    logic [31:0]   imemaddr;
    logic          ihit;
    logic [31:0]   imemload;
    logic          dmem_busy;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          halt;
    logic          valid_out;
    logic          ready_in;
    logic [31:0]   instr_out;
    logic [31:0]   npc_out;
    logic [CW-1:0] count;

    modport master (
        output imemREN, imemaddr, valid_out, instr_out, npc_out, count,
        input  ihit, imemload, dmem_busy, redirect, redirect_pc, halt, ready_in
    );

    modport slave (
        input  imemREN, imemaddr, valid_out, instr_out, npc_out, count,
        output ihit, imemload, dmem_busy, redirect, redirect_pc, halt, ready_in
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch buffer.
// It owns the fetch PC and requests a word whenever the buffer has room.
// Each returned word is queued with its next PC (fetch PC + 4) for decode.
// A MEM-stage redirect flushes the buffer and reloads the PC. A halt stops
// further fetching until reset.
//
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - fetch_queue_if.master:
//           imemREN/imemaddr/ihit/imemload  instruction memory
//           dmem_busy                       data access owns memory, fetch yields
//           redirect/redirect_pc            taken branch/jump target
//           halt                            sticky fetch stop
//           valid_out/ready_in              decode handshake
//           instr_out/npc_out               head entry contents
//           count                           occupied entries
module fetch_queue #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input logic           CLK,
    input logic           nRST,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          halted;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   npc_mem   [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full = (count_q == CW'(DEPTH));

    // Request only with guaranteed space: a pop this cycle does not count,
    // which keeps ready_in out of the imemREN path.
    assign bus.imemREN  = !halted && !bus.dmem_busy && !full;
    assign bus.imemaddr = fetch_pc;

    // A redirect in flight makes the head entry wrong-path, so hide it now.
    assign bus.valid_out = (count_q != '0) && !bus.redirect;

    assign push = bus.imemREN && bus.ihit && !bus.redirect;
    assign pop  = bus.valid_out && bus.ready_in;

    assign bus.instr_out = instr_mem[rd_ptr];
    assign bus.npc_out   = npc_mem[rd_ptr];
    assign bus.count     = count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_pc <= PC_INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            halted   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                npc_mem[i]   <= '0;
            end
        end else begin
            if (bus.halt) begin
                halted <= 1'b1;
            end

            if (bus.redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count_q  <= '0;
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    instr_mem[wr_ptr] <= bus.imemload;
                    npc_mem[wr_ptr]   <= fetch_pc + 32'd4;
                    wr_ptr            <= wr_ptr + PW'(1);
                    fetch_pc          <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by random traffic. Each
// output is compared against a queue-based reference of the fetch stage.
module tb_fetch_queue;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h0;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic nrst;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model state
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_halted;

    int total;
    int passed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // compare every combinational output against the model
    task automatic check_outputs();
        logic ren_e;
        logic val_e;
        ren_e = !m_halted && !bus.dmem_busy && (m_q.size() < DEPTH);
        val_e = (m_q.size() != 0) && !bus.redirect;
        chk("imemREN", {31'd0, bus.imemREN}, {31'd0, ren_e});
        chk("imemaddr", bus.imemaddr, m_pc);
        chk("valid_out", {31'd0, bus.valid_out}, {31'd0, val_e});
        chk("count", 32'(bus.count), 32'(m_q.size()));
        if (val_e) begin
            chk("instr_out", bus.instr_out, m_q[0].instr);
            chk("npc_out", bus.npc_out, m_q[0].npc);
        end
    endtask

    // driver: one full clock cycle, entered and left at the falling edge
    task automatic step(input logic ih, input logic [31:0] load, input logic db,
                        input logic rd, input logic [31:0] rpc, input logic hl,
                        input logic rdy);
        logic ren_e;
        logic do_push;
        logic do_pop;
        bus.ihit        = ih;
        bus.imemload    = load;
        bus.dmem_busy   = db;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
        bus.ready_in    = rdy;
        #1;
        check_outputs();
        ren_e   = !m_halted && !db && (m_q.size() < DEPTH);
        do_push = ren_e && ih && !rd;
        do_pop  = (m_q.size() != 0) && !rd && rdy;
        @(posedge clk);
        if (rd) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{npc: m_pc + 32'd4, instr: load});
                m_pc = m_pc + 32'd4;
            end
        end
        if (hl) m_halted = 1'b1;
        @(negedge clk);
    endtask

    // shorthand for plain fetch/decode cycles
    task automatic run(input logic ih, input logic rdy, input logic db);
        step(ih, $urandom(), db, 1'b0, 32'h0, 1'b0, rdy);
    endtask

    // asynchronous reset applied between clock edges
    task automatic apply_reset(input logic db);
        bus.ihit      = 1'b1;
        bus.dmem_busy = db;
        bus.redirect  = 1'b0;
        bus.halt      = 1'b0;
        bus.ready_in  = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        m_q.delete();
        m_pc     = PC_INIT;
        m_halted = 1'b0;
        chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_addr", bus.imemaddr, PC_INIT);
        chk("rst_ren", {31'd0, bus.imemREN}, {31'd0, !db});
        chk("rst_instr", bus.instr_out, 32'd0);
        chk("rst_npc", bus.npc_out, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        total           = 0;
        passed          = 0;
        nrst            = 1'b0;
        bus.ihit        = 1'b0;
        bus.imemload    = '0;
        bus.dmem_busy   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.ready_in    = 1'b0;
        m_pc            = PC_INIT;
        m_halted        = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        // reset values, with and without a data access in progress
        apply_reset(1'b1);
        apply_reset(1'b0);

        // fill: four pushes, then full with fetch stopped at 0x10
        repeat (4) run(1'b1, 1'b0, 1'b0);
        run(1'b1, 1'b0, 1'b0);
        chk("fill_addr", bus.imemaddr, 32'h10);
        chk("fill_count", 32'(bus.count), 32'd4);

        // drain in order
        repeat (5) run(1'b0, 1'b1, 1'b0);

        // simultaneous push/pop at count 2
        repeat (2) run(1'b1, 1'b0, 1'b0);
        repeat (5) run(1'b1, 1'b1, 1'b0);
        chk("pp_count", 32'(bus.count), 32'd2);

        // redirect flush from count 3
        run(1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h103, 1'b0, 1'b1);
        chk("redir_addr", bus.imemaddr, 32'h100);
        chk("redir_count", 32'(bus.count), 32'd0);
        repeat (3) run(1'b1, 1'b1, 1'b0);

        // yield to data accesses, then resume
        repeat (3) run(1'b1, 1'b0, 1'b1);
        repeat (2) run(1'b1, 1'b0, 1'b0);

        // push/pop at count DEPTH-1
        repeat (2) run(1'b1, 1'b1, 1'b0);

        // halt pulse at count 2, drain, redirect still applies
        apply_reset(1'b0);
        repeat (2) run(1'b1, 1'b0, 1'b0);
        step(1'b1, $urandom(), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) run(1'b1, 1'b0, 1'b0);
        repeat (4) run(1'b1, 1'b1, 1'b0);
        step(1'b1, $urandom(), 1'b0, 1'b1, 32'h0000_2002, 1'b0, 1'b1);
        repeat (2) run(1'b1, 1'b1, 1'b0);

        // reset mid-drain
        apply_reset(1'b0);
        repeat (3) run(1'b1, 1'b0, 1'b0);
        run(1'b0, 1'b1, 1'b0);
        apply_reset(1'b0);
        run(1'b1, 1'b1, 1'b0);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            if (n % 90 == 89) begin
                apply_reset($urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 3) != 0, $urandom(),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
                     $urandom(), $urandom_range(0, 149) == 0,
                     $urandom_range(0, 2) != 0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
